// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding and
// the bundled stall/flush control word.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_flush;
  } ctl_t;

  localparam ctl_t CTL_NORMAL   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam ctl_t CTL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctl_t CTL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam ctl_t CTL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctl_t CTL_HALT     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard inputs from the pipeline and the stall/flush controls returned to it.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_Rt;
  logic [4:0]       IF_ID_Rs;
  logic [4:0]       IF_ID_Rt;
  logic             Branch_Taken;
  logic             Mem_Req;
  logic             Mem_Ready;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             EX_MEM_Write;
  logic             MEM_WB_Flush;
  logic [CNT_W-1:0] Stall_Count;
  logic             Mem_Error;

  modport master (
    output ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt,
    output Branch_Taken, Mem_Req, Mem_Ready,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
    input  EX_MEM_Write, MEM_WB_Flush, Stall_Count, Mem_Error
  );

  modport slave (
    input  ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt,
    input  Branch_Taken, Mem_Req, Mem_Ready,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
    output EX_MEM_Write, MEM_WB_Flush, Stall_Count, Mem_Error
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Enable-gated up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze with
// timeout, taken-branch flush, load-use bubble, plus a stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard_ctrl_if.slave   bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_mem_err;
  logic              w_mem_err_nxt;
  logic              w_mem_wait;
  logic              w_load_use;
  ctl_t              w_run_ctl;
  ctl_t              w_ctl;

  assign w_mem_wait = bus.Mem_Req && !bus.Mem_Ready;
  assign w_load_use = bus.ID_EX_MemRead && (bus.ID_EX_Rt != REG_ZERO) &&
                      ((bus.ID_EX_Rt == bus.IF_ID_Rs) || (bus.ID_EX_Rt == bus.IF_ID_Rt));

  // A taken branch kills the ID instruction, so its load-use hazard is moot.
  always_comb begin
    w_run_ctl = CTL_NORMAL;
    if (bus.Branch_Taken) begin
      w_run_ctl = CTL_BRANCH;
    end else if (w_load_use) begin
      w_run_ctl = CTL_LOAD_USE;
    end
  end

  always_comb begin
    w_ctl          = CTL_NORMAL;
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_err_nxt  = r_mem_err;
    case (r_state)
      ST_RUN: begin
        if (w_mem_wait) begin
          w_ctl          = CTL_FREEZE;
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
          w_ctl = w_run_ctl;
        end
      end
      ST_MEM_WAIT: begin
        // r_wait_cnt is the ordinal of the current non-ready cycle; a ready
        // response on the limit cycle still completes normally.
        if (!bus.Mem_Ready) begin
          w_ctl = CTL_FREEZE;
          if (r_wait_cnt == WAIT_LIMIT) begin
            w_state_nxt   = ST_ERROR;
            w_mem_err_nxt = 1'b1;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
          end
        end else begin
          w_ctl          = w_run_ctl;
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end
      end
      ST_ERROR: begin
        w_ctl = CTL_HALT;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_err  <= w_mem_err_nxt;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (!w_ctl.pc_write),
    .o_cnt (bus.Stall_Count)
  );

  assign bus.PC_Write     = w_ctl.pc_write;
  assign bus.IF_ID_Write  = w_ctl.if_id_write;
  assign bus.IF_ID_Flush  = w_ctl.if_id_flush;
  assign bus.ID_EX_Flush  = w_ctl.id_ex_flush;
  assign bus.EX_MEM_Write = w_ctl.ex_mem_write;
  assign bus.MEM_WB_Flush = w_ctl.mem_wb_flush;
  assign bus.Mem_Error    = r_mem_err;

endmodule
